// File: rtl/pes_gc_pkg.sv
// Shared types and gray/binary helpers for the parametrised gray-code counter.
// The helpers work at MAX_WIDTH; narrower callers zero-extend and truncate.
package pes_gc_pkg;

  localparam int MAX_WIDTH = 32;

  // Operation selected for the counter register at the next edge.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } gc_op_e;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave the result unchanged.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/pes_gray2bin.sv
// Combinational gray-to-binary decoder: each binary bit is the XOR of all
// gray bits at and above its position.
module pes_gray2bin #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^(i_gray >> i);
  end

endmodule

// File: rtl/pes_gccounter_param.sv
// Parametrised up/down gray-code counter with parallel gray load, wrap or
// saturate at the range ends, terminal-count decode and a registered wrap pulse.
module pes_gccounter_param
  import pes_gc_pkg::*;
#(
  parameter int                   WIDTH     = 8,
  parameter int                   SATURATE  = 0,
  parameter logic [MAX_WIDTH-1:0] RESET_BIN = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_count,
  output logic [WIDTH-1:0] bin_count,
  output logic             tc,
  output logic             wrap
);

  localparam bit                   SAT          = (SATURATE != 0);
  localparam logic [WIDTH-1:0]     RESET_B      = RESET_BIN[WIDTH-1:0];
  localparam logic [MAX_WIDTH-1:0] RESET_G_FULL = bin2gray(MAX_WIDTH'(RESET_B));
  localparam logic [WIDTH-1:0]     RESET_G      = RESET_G_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;
  logic             w_at_max;
  logic             w_at_min;
  gc_op_e           w_op;

  pes_gray2bin #(
    .WIDTH (WIDTH)
  ) u_load_dec (
    .i_gray (load_gray),
    .o_bin  (w_load_bin)
  );

  assign w_at_max = &r_bin;
  assign w_at_min = ~|r_bin;

  // Load has priority over stepping; enable is ignored while loading.
  always_comb begin
    w_op = OP_HOLD;
    if (load) begin
      w_op = OP_LOAD;
    end else if (enable) begin
      w_op = up_dn ? OP_UP : OP_DOWN;
    end
  end

  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    unique case (w_op)
      OP_LOAD: w_bin_next = w_load_bin;
      OP_UP: begin
        if (!w_at_max) begin
          w_bin_next = r_bin + WIDTH'(1);
        end else if (!SAT) begin
          w_bin_next  = '0;
          w_wrap_next = 1'b1;
        end
      end
      OP_DOWN: begin
        if (!w_at_min) begin
          w_bin_next = r_bin - WIDTH'(1);
        end else if (!SAT) begin
          w_bin_next  = '1;
          w_wrap_next = 1'b1;
        end
      end
      default: begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
      end
    endcase
  end

  // Gray is encoded from the next binary value so both outputs are plain flops.
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bin  <= RESET_B;
      r_gray <= RESET_G;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign gray_count = r_gray;
  assign bin_count  = r_bin;
  assign wrap       = r_wrap;
  assign tc         = up_dn ? w_at_max : w_at_min;

endmodule

// File: tb/tb_pes_gccounter_param.sv
// Scoreboard bench: four counter configurations share one stimulus stream; an
// arithmetic reference model queues expectations that a monitor checks each cycle.
module tb_pes_gccounter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, ud, ld;
  logic [7:0] lg;

  logic [3:0] g0, b0, g1, b1, g2, b2;
  logic [7:0] g3, b3;
  logic [3:0] tcv, wrv;

  pes_gccounter_param #(.WIDTH(4), .SATURATE(0), .RESET_BIN(32'd0)) u_w4 (
    .clk(clk), .reset(rst_n), .enable(en), .up_dn(ud), .load(ld), .load_gray(lg[3:0]),
    .gray_count(g0), .bin_count(b0), .tc(tcv[0]), .wrap(wrv[0]));
  pes_gccounter_param #(.WIDTH(4), .SATURATE(1), .RESET_BIN(32'd0)) u_w4s (
    .clk(clk), .reset(rst_n), .enable(en), .up_dn(ud), .load(ld), .load_gray(lg[3:0]),
    .gray_count(g1), .bin_count(b1), .tc(tcv[1]), .wrap(wrv[1]));
  pes_gccounter_param #(.WIDTH(4), .SATURATE(0), .RESET_BIN(32'd5)) u_w4r5 (
    .clk(clk), .reset(rst_n), .enable(en), .up_dn(ud), .load(ld), .load_gray(lg[3:0]),
    .gray_count(g2), .bin_count(b2), .tc(tcv[2]), .wrap(wrv[2]));
  pes_gccounter_param #(.WIDTH(8), .SATURATE(0), .RESET_BIN(32'd0)) u_w8 (
    .clk(clk), .reset(rst_n), .enable(en), .up_dn(ud), .load(ld), .load_gray(lg),
    .gray_count(g3), .bin_count(b3), .tc(tcv[3]), .wrap(wrv[3]));

  logic [3:0][7:0] act_gray, act_bin;
  assign act_gray = {g3, {4'h0, g2}, {4'h0, g1}, {4'h0, g0}};
  assign act_bin  = {b3, {4'h0, b2}, {4'h0, b1}, {4'h0, b0}};

  typedef struct packed {
    logic [3:0][7:0] gray;
    logic [3:0][7:0] bin;
    logic [3:0]      wrap;
    logic [3:0]      tc;
    logic [3:0]      onebit;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic [3:0][7:0] prev_gray;

  int total = 0;
  int bad   = 0;

  int mw[4]   = '{4, 4, 4, 8};
  int msat[4] = '{0, 1, 0, 0};
  int mrb[4]  = '{0, 0, 5, 0};
  int m[4];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", name, idx, act, want, $time);
    end
  endtask

  // Inverse of the gray definition found by search, independent of any decoder.
  function automatic int gray_to_int(input int g, input int w);
    for (int v = 0; v < (1 << w); v++) begin
      if ((v ^ (v >> 1)) == g) return v;
    end
    return -1;
  endfunction

  task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [7:0] g);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; ud = u; ld = l; lg = g;
    for (int i = 0; i < 4; i++) begin
      int size, top;
      logic wr, ob;
      size = 1 << mw[i];
      top  = size - 1;
      wr   = 1'b0;
      ob   = 1'b0;
      if (!r) begin
        m[i] = mrb[i];
      end else if (l) begin
        m[i] = gray_to_int(int'(g) % size, mw[i]);
      end else if (e) begin
        if (u) begin
          if (!(msat[i] != 0 && m[i] == top)) begin
            wr   = (m[i] == top);
            m[i] = (m[i] + 1) % size;
            ob   = 1'b1;
          end
        end else begin
          if (!(msat[i] != 0 && m[i] == 0)) begin
            wr   = (m[i] == 0);
            m[i] = (m[i] + size - 1) % size;
            ob   = 1'b1;
          end
        end
      end
      x.gray[i]   = 8'(m[i] ^ (m[i] >> 1));
      x.bin[i]    = 8'(m[i]);
      x.wrap[i]   = wr;
      x.tc[i]     = u ? (m[i] == top) : (m[i] == 0);
      x.onebit[i] = ob;
    end
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk("gray", i, act_gray[i], mon_e.gray[i]);
        chk("bin", i, act_bin[i], mon_e.bin[i]);
        chk("wrap", i, 8'(wrv[i]), 8'(mon_e.wrap[i]));
        chk("tc", i, 8'(tcv[i]), 8'(mon_e.tc[i]));
        if (mon_e.onebit[i]) begin
          chk("onebit", i, 8'($countones(prev_gray[i] ^ act_gray[i])), 8'd1);
        end
        prev_gray[i] = act_gray[i];
      end
    end
  end

  initial begin
    logic [7:0] saved;
    logic       r, e, u, l;
    rst_n = 1'b0; en = 1'b0; ud = 1'b1; ld = 1'b0; lg = '0;

    drive(0, 0, 1, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    repeat (20) drive(1, 1, 1, 0, 8'h00);

    // Down from reset: wrap to all-ones; saturating copy holds at zero.
    drive(0, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h00);
    drive(1, 1, 0, 0, 8'h00);
    drive(1, 1, 0, 0, 8'h00);

    // Load wins over enable, then a normal step follows.
    drive(1, 1, 1, 1, 8'h06);
    @(posedge clk); #2;
    chk("load_gray", 0, act_gray[0], 8'h06);
    chk("load_bin", 0, act_bin[0], 8'h04);
    drive(1, 1, 1, 0, 8'h00);
    @(posedge clk); #2;
    chk("load_step", 0, act_gray[0], 8'h07);

    // Reset overrides load mid-count.
    repeat (3) drive(1, 1, 1, 0, 8'h00);
    drive(0, 1, 1, 1, 8'h0f);
    @(posedge clk); #2;
    chk("rst_over_load", 0, act_gray[0], 8'h00);
    chk("rst_over_load", 2, act_gray[2], 8'h07);
    chk("rst_wrap", 0, 8'(wrv[0]), 8'h00);

    // Up then down returns to the prior code.
    repeat (37) drive(1, 1, 1, 0, 8'h00);
    saved = 8'(m[3] ^ (m[3] >> 1));
    drive(1, 1, 1, 0, 8'h00);
    drive(1, 1, 0, 0, 8'h00);
    @(posedge clk); #2;
    chk("reversal", 3, act_gray[3], saved);
    saved = 8'(m[3] ^ (m[3] >> 1));
    drive(1, 1, 0, 0, 8'h00);
    drive(1, 1, 1, 0, 8'h00);
    @(posedge clk); #2;
    chk("reversal", 3, act_gray[3], saved);

    u = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) u = ~u;
      l = ($urandom_range(0, 29) == 0);
      drive(r, e, u, l, 8'($urandom));
    end

    repeat (2) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
